// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: request/response bundle for the serial adder/subtractor.
//   start, mode, cin, a, b      : request side, driven by the master
//   busy, done, sum, cout, ovf,
//   zero                        : status/result side, driven by the slave (the core)
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic             mode;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, cin, a, b,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, mode, cin, a, b,
    output busy, done, sum, cout, ovf, zero
  );

endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor processing DIGIT bits per clock.
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of serial_add_sub_if
//            start/mode/cin/a/b latched when not busy; busy high during RUN;
//            done pulses one cycle when sum/cout/ovf/zero update.
// Latency: results and done visible WIDTH/DIGIT cycles after the start edge.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_sub_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 2) || (DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Digit slice: DIGIT chained full adders fed by the low bits of the operand shift
  // registers and the registered carry.
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;  // carry into the top bit of this digit
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    logic c;
    c        = carry_q;
    dig_cmsb = carry_q;
    dig_sum  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dig_cmsb   = c;
      dig_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    dig_cout = c;
  end

  // New digit enters from the MSB side so that after N steps the LSB digit lands at bit 0.
  assign res_shift = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

  logic last_digit;
  assign last_digit = (cnt_q == CntW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          // Subtraction is a + ~b + ~borrow; mode is folded in here and not kept.
          a_d     = bus.a;
          b_d     = bus.mode ? ~bus.b : bus.b;
          carry_d = bus.mode ? ~bus.cin : bus.cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_digit) begin
          // On the last digit, dig_cmsb is the carry into bit WIDTH-1.
          sum_d   = res_shift;
          cout_d  = dig_cout;
          ovf_d   = dig_cmsb ^ dig_cout;
          zero_d  = (res_shift == '0);
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule
